// File: rtl/weight_fetch_seq.sv
// Weight memory read sequencer: walks addresses 0..NUM_WEIGHT-1 through a
// 1-cycle-latency read port and streams the weights out over valid/ready.
module weight_fetch_seq #(
   parameter int NUM_WEIGHT = 30,
   parameter int ADDR_WIDTH = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_radd,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic [ADDR_WIDTH-1:0] w_idx,
   output logic                  w_last
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_issue_cnt;
   logic                  r_inflight;
   logic [ADDR_WIDTH-1:0] r_inflight_idx;
   logic [DATA_WIDTH-1:0] r_fifo_data [2];
   logic [ADDR_WIDTH-1:0] r_fifo_idx [2];
   logic [1:0]            r_fifo_last;
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic                  r_done;

   logic                  w_valid_int;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_head_last;
   logic                  w_issue;
   logic                  w_last_issue;

   // A read may issue only while FIFO occupancy plus the read in flight, net of
   // this cycle's pop, leaves room; this keeps the 2-entry FIFO from overflowing.
   always_comb begin
      w_valid_int  = (r_count != 2'd0);
      w_pop        = w_valid_int & w_ready;
      w_push       = r_inflight;
      w_head_last  = r_fifo_last[r_rd_ptr];
      w_issue      = (r_state == S_FETCH) &&
                     (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
      w_last_issue = w_issue && (r_issue_cnt == LAST_IDX);
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_FETCH;
         S_FETCH: if (w_last_issue) w_state_next = S_DRAIN;
         S_DRAIN: if (w_pop && w_head_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_issue_cnt    <= '0;
         r_inflight     <= 1'b0;
         r_inflight_idx <= '0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_inflight     <= w_issue;
         r_inflight_idx <= r_issue_cnt;
         r_done         <= (r_state == S_DRAIN) && w_pop && w_head_last;
         // Counter holds on the last address so it never wraps.
         if (r_state == S_IDLE)
            r_issue_cnt <= '0;
         else if (w_issue && !w_last_issue)
            r_issue_cnt <= r_issue_cnt + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_idx[i]  <= '0;
         end
         r_fifo_last <= 2'b00;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
            r_fifo_idx[r_wr_ptr]  <= r_inflight_idx;
            r_fifo_last[r_wr_ptr] <= (r_inflight_idx == LAST_IDX);
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Beat fields are forced to zero when no beat is presented.
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign mem_ren  = w_issue;
   assign mem_radd = r_issue_cnt;
   assign w_valid  = w_valid_int;
   assign w_data   = w_valid_int ? r_fifo_data[r_rd_ptr] : '0;
   assign w_idx    = w_valid_int ? r_fifo_idx[r_rd_ptr] : '0;
   assign w_last   = w_valid_int & w_head_last;

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Bench for weight_fetch_seq: cycle table, hand sequences and randomized runs
// checked against a stream-level model of the expected weight sequence.
module tb_weight_fetch_seq;

   logic        clk;
   logic        rst_n;
   logic        start, w_ready;
   logic [15:0] mem_rdata;
   logic        busy, done, mem_ren, w_valid, w_last;
   logic [4:0]  mem_radd, w_idx;
   logic [15:0] w_data;

   logic        start1, ready1;
   logic [15:0] rdata1;
   logic        busy1, done1, ren1, valid1, last1;
   logic [0:0]  radd1, idx1;
   logic [15:0] data1;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mem [32];

   weight_fetch_seq #(.NUM_WEIGHT(30), .DATA_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_rdata(mem_rdata),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx), .w_last(w_last));

   weight_fetch_seq #(.NUM_WEIGHT(1), .DATA_WIDTH(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .mem_ren(ren1), .mem_radd(radd1), .mem_rdata(rdata1),
      .w_valid(valid1), .w_ready(ready1), .w_data(data1), .w_idx(idx1), .w_last(last1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROMs with registered read data
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= mem[mem_radd];
      if (ren1)    rdata1    <= 16'hA5C3;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a run is the sequence (mem[i], i, i==29) for i = 0..29,
   // each delivered exactly once in order; reads issued minus beats accepted
   // never exceeds 2; done follows the last accepted beat by one cycle.
   int          cyc = 0, total_beats = 0, total_dones = 0;
   int          exp_idx = 0, issued = 0, accepted = 0;
   int          first_acc_cyc = 0, last_acc_cyc = 0;
   logic        done_due = 1'b0, stall_prev = 1'b0;
   logic [15:0] prev_data = '0;
   logic [4:0]  prev_idx = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_idx = 0; issued = 0; accepted = 0;
         done_due = 1'b0; stall_prev = 1'b0;
      end else begin
         if (start && !busy) begin
            exp_idx = 0; issued = 0; accepted = 0;
         end
         chk("done_timing", int'(done), int'(done_due));
         if (done) total_dones++;
         done_due = 1'b0;
         if (stall_prev)
            chk("stall_hold", int'({w_valid, w_idx, w_data}), int'({1'b1, prev_idx, prev_data}));
         if (mem_ren) begin
            chk("radd_seq", int'(mem_radd), issued);
            issued++;
         end
         if (w_valid && w_ready) begin
            chk("beat_idx", int'(w_idx), exp_idx);
            chk("beat_data", int'(w_data), int'(mem[exp_idx % 32]));
            chk("beat_last", int'(w_last), int'(exp_idx == 29));
            if (exp_idx == 29) done_due = 1'b1;
            if (exp_idx == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            exp_idx++; accepted++; total_beats++;
         end
         chk("occupancy", int'((issued - accepted) <= 2), 1);
         stall_prev = w_valid && !w_ready;
         prev_data  = w_data;
         prev_idx   = w_idx;
      end
   end

   task automatic chk_quiet(input string name);
      chk(name, int'({busy, done, mem_ren, mem_radd, w_valid, w_data, w_idx, w_last}), 0);
   endtask

   // Starts a run in the current cycle and returns in the cycle done is seen.
   // mode 0: ready held high, 1: ready toggles, 2: random ready.
   task automatic run_until_done(input int mode, input bit poke, output bit got);
      got = 1'b0;
      start = 1'b1;
      w_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (done) begin
            got = 1'b1;
            break;
         end
         start = poke && (k == 5 || k == 30 || k == 45);
         case (mode)
            0:       w_ready = 1'b1;
            1:       w_ready = ~w_ready;
            default: w_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
      start = 1'b0;
   endtask

   typedef struct {
      logic st, rd;
      logic busy, ren;
      logic [4:0] radd;
      logic val;
      logic [4:0] idx;
      logic last, dn;
   } vec_t;

   vec_t tbl [16];
   int   b0, d0;
   bit   got;

   initial begin
      tbl[0]  = '{st:1, rd:0, busy:0, ren:0, radd:0, val:0, idx:0, last:0, dn:0};
      tbl[1]  = '{st:0, rd:0, busy:1, ren:1, radd:0, val:0, idx:0, last:0, dn:0};
      tbl[2]  = '{st:0, rd:0, busy:1, ren:1, radd:1, val:0, idx:0, last:0, dn:0};
      for (int i = 3; i < 13; i++)
         tbl[i] = '{st:0, rd:0, busy:1, ren:0, radd:2, val:1, idx:0, last:0, dn:0};
      tbl[13] = '{st:0, rd:1, busy:1, ren:1, radd:2, val:1, idx:0, last:0, dn:0};
      tbl[14] = '{st:0, rd:1, busy:1, ren:1, radd:3, val:1, idx:1, last:0, dn:0};
      tbl[15] = '{st:0, rd:1, busy:1, ren:1, radd:4, val:1, idx:2, last:0, dn:0};

      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom_range(0, 65535));
      rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;

      // Reset state
      @(negedge clk);
      chk_quiet("reset_state");
      chk("reset_dut1", int'({busy1, done1, ren1, valid1, last1}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full run, ready high: latency, no bubbles, single done
      b0 = total_beats; d0 = total_dones;
      start = 1'b1; w_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("lat_first_ren", int'({mem_ren, mem_radd, busy}), int'({1'b1, 5'd0, 1'b1}));
      chk("lat_no_valid_c1", int'(w_valid), 0);
      @(negedge clk);
      chk("lat_no_valid_c2", int'(w_valid), 0);
      @(negedge clk);
      chk("lat_first_valid", int'({w_valid, w_idx}), int'({1'b1, 5'd0}));
      for (int k = 0; k < 100 && !done; k++) begin
         @(posedge clk); #1;
      end
      chk("t1_done_seen", int'(done), 1);
      chk("t1_busy_drop", int'(busy), 0);
      @(negedge clk); #1;
      chk("t1_beats", total_beats - b0, 30);
      chk("t1_dones", total_dones - d0, 1);
      chk("t1_no_bubble", last_acc_cyc - first_acc_cyc, 29);

      // Ready toggling every cycle
      @(posedge clk); #1;
      b0 = total_beats; d0 = total_dones;
      run_until_done(1, 1'b0, got);
      chk("t2_done_seen", int'(got), 1);
      @(negedge clk); #1;
      chk("t2_beats", total_beats - b0, 30);
      chk("t2_dones", total_dones - d0, 1);

      // Cycle table: 10 stalled cycles after start, then release
      @(posedge clk); #1;
      b0 = total_beats;
      for (int i = 0; i < 16; i++) begin
         start = tbl[i].st; w_ready = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("tbl_row%0d", i),
             int'({busy, mem_ren, mem_radd, w_valid, w_idx, w_last, done}),
             int'({tbl[i].busy, tbl[i].ren, tbl[i].radd, tbl[i].val, tbl[i].idx, tbl[i].last, tbl[i].dn}));
         @(posedge clk); #1;
      end
      for (int k = 0; k < 100 && !done; k++) begin
         @(posedge clk); #1;
      end
      chk("t3_done_seen", int'(done), 1);
      @(negedge clk); #1;
      chk("t3_beats", total_beats - b0, 30);

      // Start poked in FETCH and DRAIN, then start in the done cycle
      @(posedge clk); #1;
      b0 = total_beats; d0 = total_dones;
      run_until_done(0, 1'b1, got);
      chk("t4_done_run1", int'(got), 1);
      run_until_done(0, 1'b0, got);
      chk("t4_done_run2", int'(got), 1);
      @(negedge clk); #1;
      chk("t4_beats", total_beats - b0, 60);
      chk("t4_dones", total_dones - d0, 2);

      // Randomized runs with random backpressure and stray starts
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 32; i++) mem[i] = 16'($urandom_range(0, 65535));
         repeat ($urandom_range(1, 4)) @(posedge clk);
         #1;
         b0 = total_beats; d0 = total_dones;
         run_until_done(2, r[0], got);
         chk("rnd_done_seen", int'(got), 1);
         @(negedge clk); #1;
         chk("rnd_beats", total_beats - b0, 30);
         chk("rnd_dones", total_dones - d0, 1);
      end

      // Reset mid-run with FIFO full
      @(posedge clk); #1;
      b0 = total_beats;
      start = 1'b1; w_ready = 1'b1;
      for (int k = 0; k < 100 && (total_beats - b0) < 12; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      w_ready = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("t5_fifo_full", int'({w_valid, mem_ren}), int'({1'b1, 1'b0}));
      rst_n = 1'b0;
      #1;
      chk_quiet("t5_async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      b0 = total_beats;
      w_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t5_quiet", int'({busy, mem_ren, w_valid}), 0);
      end
      chk("t5_no_beats", total_beats - b0, 0);
      @(posedge clk); #1;
      run_until_done(0, 1'b0, got);
      chk("t5_rerun_done", int'(got), 1);
      @(negedge clk); #1;
      chk("t5_rerun_beats", total_beats - b0, 30);

      // Single-weight build
      @(posedge clk); #1;
      start1 = 1'b1; ready1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      chk("n1_issue", int'({ren1, radd1, busy1}), int'({1'b1, 1'b0, 1'b1}));
      @(negedge clk);
      chk("n1_no_valid", int'(valid1), 0);
      @(negedge clk);
      chk("n1_beat", int'({valid1, idx1, last1, data1}), int'({1'b1, 1'b0, 1'b1, 16'hA5C3}));
      @(negedge clk);
      chk("n1_done", int'({done1, busy1, valid1}), int'({1'b1, 1'b0, 1'b0}));
      @(negedge clk);
      chk("n1_done_pulse", int'(done1), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
      $fatal(1);
   end

endmodule
